// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase countdown timer; PHASE_TIMER_RUNTIME_CFG_EN adds runtime duration registers
module phase_timer #(
    parameter int CNT_W               = 8,
    parameter int RED_TIME            = 1,
    parameter int PRIMARY_GREEN_TIME  = 20,
    parameter int EXTENDED_GREEN_TIME = 30,
    parameter int YELLOW_TIME         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       state,
    input  logic             pause,
    input  logic             restart,
`ifdef PHASE_TIMER_RUNTIME_CFG_EN
    input  logic             cfg_we,
    input  logic [1:0]       cfg_sel,
    input  logic [CNT_W-1:0] cfg_data,
`endif
    output logic             expired,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    localparam longint MAXV = (longint'(1) << CNT_W) - longint'(1);

    generate
        if (longint'(RED_TIME) > MAXV || longint'(PRIMARY_GREEN_TIME) > MAXV ||
            longint'(EXTENDED_GREEN_TIME) > MAXV || longint'(YELLOW_TIME) > MAXV) begin : g_bad_param
            $error("phase_timer: a duration parameter exceeds 2**CNT_W-1");
        end
    endgenerate

    logic [3:0]       state_q;
    logic             load_pend;
    logic [1:0]       cls;
    logic [CNT_W-1:0] raw_dur;
    logic [CNT_W-1:0] dur;
    logic             load;

    // Class index: 0 red, 1 primary green, 2 extended green, 3 yellow
    always_comb begin
        cls = 2'd0;
        case (state)
            4'd1, 4'd4, 4'd7, 4'd10: cls = 2'd1;
            4'd2, 4'd5, 4'd8, 4'd11: cls = 2'd2;
            4'd3, 4'd6, 4'd9, 4'd12: cls = 2'd3;
            default:                 cls = 2'd0;
        endcase
    end

`ifdef PHASE_TIMER_RUNTIME_CFG_EN
    logic [CNT_W-1:0] dur_tab [4];

    always_ff @(posedge clk) begin
        if (!rst) begin
            dur_tab[0] <= CNT_W'(RED_TIME);
            dur_tab[1] <= CNT_W'(PRIMARY_GREEN_TIME);
            dur_tab[2] <= CNT_W'(EXTENDED_GREEN_TIME);
            dur_tab[3] <= CNT_W'(YELLOW_TIME);
        end else if (cfg_we) begin
            dur_tab[cfg_sel] <= cfg_data;
        end
    end

    assign raw_dur = dur_tab[cls];
`else
    always_comb begin
        raw_dur = CNT_W'(RED_TIME);
        case (cls)
            2'd1:    raw_dur = CNT_W'(PRIMARY_GREEN_TIME);
            2'd2:    raw_dur = CNT_W'(EXTENDED_GREEN_TIME);
            2'd3:    raw_dur = CNT_W'(YELLOW_TIME);
            default: raw_dur = CNT_W'(RED_TIME);
        endcase
    end
`endif

    // A zero duration would never produce an expiry pulse, so it runs as one cycle
    assign dur  = (raw_dur == '0) ? CNT_W'(1) : raw_dur;
    assign load = load_pend | restart | (state != state_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            remaining <= '0;
            expired   <= 1'b0;
            state_q   <= 4'd0;
            load_pend <= 1'b1;
        end else begin
            state_q <= state;
            if (load) begin
                remaining <= dur;
                expired   <= 1'b0;
                load_pend <= 1'b0;
            end else if (pause) begin
                expired <= 1'b0;
            end else if (remaining > CNT_W'(1)) begin
                remaining <= remaining - CNT_W'(1);
                expired   <= 1'b0;
            end else if (remaining == CNT_W'(1)) begin
                remaining <= '0;
                expired   <= 1'b1;
            end else begin
                expired <= 1'b0;
            end
        end
    end

    // load_pend masks done between reset and the first load
    assign done = (remaining == '0) && !load_pend;

endmodule

// File: tb/tb_phase_timer.sv
// tb/tb_phase_timer.sv - directed self-checking bench for phase_timer
module tb_phase_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] state;
    logic       pause;
    logic       restart;
    logic       expired;
    logic       done;
    logic [7:0] remaining;
`ifdef PHASE_TIMER_RUNTIME_CFG_EN
    logic       cfg_we;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    phase_timer dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .pause     (pause),
        .restart   (restart),
`ifdef PHASE_TIMER_RUNTIME_CFG_EN
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_data  (cfg_data),
`endif
        .expired   (expired),
        .done      (done),
        .remaining (remaining)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; state = 4'd0; pause = 1'b0; restart = 1'b0;
        repeat (3) step();
        checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL rst_remaining got=%0d exp=0", remaining); end
        checks++; if (expired !== 1'b0) begin errors++; $display("FAIL rst_expired got=%0b exp=0", expired); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0b exp=0", done); end
        rst = 1'b1;
        step();
        checks++; if (remaining !== 8'd1) begin errors++; $display("FAIL rel_load got=%0d exp=1", remaining); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rel_done got=%0b exp=0", done); end
        step();
        checks++; if (expired !== 1'b1) begin errors++; $display("FAIL rel_expired got=%0b exp=1", expired); end
        checks++; if (done !== 1'b1 || remaining !== 8'd0) begin errors++; $display("FAIL rel_done_hi done=%0b rem=%0d exp done=1 rem=0", done, remaining); end
        repeat (2) step();
        checks++; if (expired !== 1'b0 || done !== 1'b1 || remaining !== 8'd0) begin errors++; $display("FAIL rel_hold exp_pulse=%0b done=%0b rem=%0d exp 0/1/0", expired, done, remaining); end
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++; if (remaining !== 8'd1 || done !== 1'b0) begin errors++; $display("FAIL rearm rem=%0d done=%0b exp rem=1 done=0", remaining, done); end
        step();
        checks++; if (expired !== 1'b1) begin errors++; $display("FAIL rearm_expired got=%0b exp=1", expired); end
    endtask

    task automatic test_primary();
        state = 4'd1;
        step();
        checks++; if (remaining !== 8'd20) begin errors++; $display("FAIL prim_load got=%0d exp=20", remaining); end
        step();
        checks++; if (remaining !== 8'd19) begin errors++; $display("FAIL prim_dec got=%0d exp=19", remaining); end
        repeat (18) step();
        checks++; if (remaining !== 8'd1 || expired !== 1'b0) begin errors++; $display("FAIL prim_k19 rem=%0d exp_pulse=%0b exp rem=1 pulse=0", remaining, expired); end
        step();
        checks++; if (expired !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL prim_k20 pulse=%0b done=%0b exp 1/1", expired, done); end
        step();
        checks++; if (expired !== 1'b0) begin errors++; $display("FAIL prim_one_wide got=%0b exp=0", expired); end
    endtask

    task automatic test_pause();
        state = 4'd3;
        step();
        checks++; if (remaining !== 8'd5) begin errors++; $display("FAIL yel_load got=%0d exp=5", remaining); end
        repeat (2) step();
        pause = 1'b1;
        repeat (4) begin
            step();
            checks++; if (remaining !== 8'd3) begin errors++; $display("FAIL pause_hold got=%0d exp=3", remaining); end
        end
        pause = 1'b0;
        repeat (2) step();
        checks++; if (remaining !== 8'd1 || expired !== 1'b0) begin errors++; $display("FAIL pause_k8 rem=%0d pulse=%0b exp 1/0", remaining, expired); end
        step();
        checks++; if (expired !== 1'b1 || remaining !== 8'd0) begin errors++; $display("FAIL pause_k9 pulse=%0b rem=%0d exp 1/0", expired, remaining); end
        state = 4'd7; pause = 1'b1;
        step();
        checks++; if (remaining !== 8'd20) begin errors++; $display("FAIL load_vs_pause got=%0d exp=20", remaining); end
        step();
        checks++; if (remaining !== 8'd20) begin errors++; $display("FAIL load_then_pause got=%0d exp=20", remaining); end
        pause = 1'b0;
        step();
        checks++; if (remaining !== 8'd19) begin errors++; $display("FAIL pause_resume got=%0d exp=19", remaining); end
    endtask

    task automatic test_reload();
        state = 4'd2;
        step();
        checks++; if (remaining !== 8'd30) begin errors++; $display("FAIL ext_load got=%0d exp=30", remaining); end
        repeat (29) step();
        checks++; if (remaining !== 8'd1) begin errors++; $display("FAIL ext_at1 got=%0d exp=1", remaining); end
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++; if (remaining !== 8'd30 || expired !== 1'b0) begin errors++; $display("FAIL restart_at1 rem=%0d pulse=%0b exp 30/0", remaining, expired); end
        state = 4'd5;
        step();
        repeat (29) step();
        checks++; if (remaining !== 8'd1) begin errors++; $display("FAIL s5_at1 got=%0d exp=1", remaining); end
        state = 4'd6;
        step();
        checks++; if (remaining !== 8'd5 || expired !== 1'b0) begin errors++; $display("FAIL change_at1 rem=%0d pulse=%0b exp 5/0", remaining, expired); end
        step();
        checks++; if (remaining !== 8'd4 || expired !== 1'b0) begin errors++; $display("FAIL change_after rem=%0d pulse=%0b exp 4/0", remaining, expired); end
    endtask

    task automatic test_reset_mid();
        state = 4'd4;
        step();
        repeat (8) step();
        checks++; if (remaining !== 8'd12) begin errors++; $display("FAIL mid_pre got=%0d exp=12", remaining); end
        rst = 1'b0;
        step();
        checks++; if (remaining !== 8'd0 || expired !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst rem=%0d pulse=%0b done=%0b exp 0/0/0", remaining, expired, done); end
        rst = 1'b1;
        step();
        checks++; if (remaining !== 8'd20 || expired !== 1'b0) begin errors++; $display("FAIL mid_reload rem=%0d pulse=%0b exp 20/0", remaining, expired); end
        step();
        checks++; if (remaining !== 8'd19) begin errors++; $display("FAIL mid_count got=%0d exp=19", remaining); end
    endtask

    task automatic test_decode();
        logic [7:0] exp_dur [16];
        exp_dur = '{8'd1, 8'd20, 8'd30, 8'd5, 8'd20, 8'd30, 8'd5, 8'd20,
                    8'd30, 8'd5, 8'd20, 8'd30, 8'd5, 8'd1, 8'd1, 8'd1};
        for (int s = 0; s < 16; s++) begin
            state = 4'(s);
            step();
            checks++; if (remaining !== exp_dur[s]) begin errors++; $display("FAIL decode_s%0d got=%0d exp=%0d", s, remaining, exp_dur[s]); end
        end
    endtask

`ifdef PHASE_TIMER_RUNTIME_CFG_EN
    task automatic test_cfg();
        state = 4'd1; cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 8'd2;
        step();
        cfg_we = 1'b0;
        checks++; if (remaining !== 8'd20) begin errors++; $display("FAIL cfg_green_unaffected got=%0d exp=20", remaining); end
        state = 4'd3;
        step();
        checks++; if (remaining !== 8'd2) begin errors++; $display("FAIL cfg_yellow got=%0d exp=2", remaining); end
        repeat (2) step();
        checks++; if (expired !== 1'b1) begin errors++; $display("FAIL cfg_yellow_exp got=%0b exp=1", expired); end
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 8'd0;
        step();
        cfg_we = 1'b0;
        state = 4'd4;
        step();
        checks++; if (remaining !== 8'd1) begin errors++; $display("FAIL cfg_zero got=%0d exp=1", remaining); end
        step();
        checks++; if (expired !== 1'b1 || remaining !== 8'd0) begin errors++; $display("FAIL cfg_zero_exp pulse=%0b rem=%0d exp 1/0", expired, remaining); end
    endtask
`endif

    initial begin
`ifdef PHASE_TIMER_RUNTIME_CFG_EN
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
`endif
        test_reset();
        test_primary();
        test_pause();
        test_reload();
        test_reset_mid();
        test_decode();
`ifdef PHASE_TIMER_RUNTIME_CFG_EN
        test_cfg();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
